// File: rtl/sysid_pkg.sv
// sysid_pkg: shared constants and state encoding for the system ID checker
package sysid_pkg;
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;
  localparam logic [31:0] DEF_EXPECTED_ID = 32'h0000_0000;
  localparam logic [31:0] DEF_EXPECTED_TS = 32'h52FA_899C;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_ID  = 3'd1;
  localparam logic [2:0] S_LAT_ID = 3'd2;
  localparam logic [2:0] S_RD_TS  = 3'd3;
  localparam logic [2:0] S_LAT_TS = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  typedef enum logic [2:0] {
    IDLE   = S_IDLE,
    RD_ID  = S_RD_ID,
    LAT_ID = S_LAT_ID,
    RD_TS  = S_RD_TS,
    LAT_TS = S_LAT_TS,
    DONE   = S_DONE
  } state_e;
endpackage

// File: rtl/sysid_if.sv
// sysid_if: Avalon-MM read-only link between the checker and the system ID slave
interface sysid_if;
  logic        address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;
  modport master (output address, read, input waitrequest, readdata);
  modport slave (input address, read, output waitrequest, readdata);
endinterface

// File: rtl/sysid_rd_engine.sv
// sysid_rd_engine: one Avalon read with stall timeout and fixed read latency
module sysid_rd_engine #(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic rd,
  input  logic lat,
  input  logic waitrequest,
  output logic read,
  output logic accept,
  output logic capture,
  output logic timeout
);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  LAT_LAST  = 2'(READ_LATENCY == 0 ? 0 : READ_LATENCY - 1);
  logic [15:0] wcnt;
  logic [1:0]  lcnt;
  assign read    = rd;
  assign accept  = rd && !waitrequest;
  assign timeout = rd && waitrequest && wcnt == WAIT_LAST;
  assign capture = (READ_LATENCY == 0) ? accept : lat && lcnt == LAT_LAST;
  // consecutive stall cycles of the current read; cleared on acceptance or abort
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) wcnt <= '0;
    else wcnt <= (rd && waitrequest && !timeout) ? wcnt + 16'd1 : '0;
  end
  // cycles spent waiting for readdata after acceptance
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lcnt <= '0;
    else lcnt <= lat ? lcnt + 2'd1 : '0;
  end
endmodule

// File: rtl/sysid_checker.sv
// sysid_checker: reads ID and timestamp from the system ID slave and checks them
module sysid_checker import sysid_pkg::*; #(
  parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  sysid_if.master     sysid,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        timeout_err
);
  logic [2:0] state, state_nx;
  logic pend, armed, id_eq, start_ok;
  logic rd, lat, is_ts, accept, capture, timeout;
  assign start_ok      = start && armed;
  assign rd            = state == S_RD_ID || state == S_RD_TS;
  assign lat           = state == S_LAT_ID || state == S_LAT_TS;
  assign is_ts         = state == S_RD_TS || state == S_LAT_TS;
  assign busy          = rd || lat;
  assign done          = state == S_DONE;
  assign sysid.address = (state == S_RD_TS) ? ADDR_TS : ADDR_ID;
  sysid_rd_engine #(
    .READ_LATENCY  (READ_LATENCY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_engine (
    .clock      (clock),
    .reset_n    (reset_n),
    .rd         (rd),
    .lat        (lat),
    .waitrequest(sysid.waitrequest),
    .read       (sysid.read),
    .accept     (accept),
    .capture    (capture),
    .timeout    (timeout)
  );
  // sequence the ID read then the timestamp read; a timeout on either ends the check
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = pend ? S_RD_ID : S_IDLE;
      S_RD_ID:  state_nx = timeout ? S_DONE : !accept ? S_RD_ID : (READ_LATENCY == 0) ? S_RD_TS : S_LAT_ID;
      S_LAT_ID: state_nx = capture ? S_RD_TS : S_LAT_ID;
      S_RD_TS:  state_nx = timeout ? S_DONE : !accept ? S_RD_TS : (READ_LATENCY == 0) ? S_DONE : S_LAT_TS;
      S_LAT_TS: state_nx = capture ? S_DONE : S_LAT_TS;
      S_DONE:   state_nx = start_ok ? S_IDLE : S_DONE;
      default:  state_nx = S_IDLE;
    endcase
  end
  // state register; reset drops the read strobe without waiting for a clock
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else state <= state_nx;
  end
  // start is ignored on the first edge after reset release, when the release may still be settling
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) armed <= 1'b0;
    else armed <= 1'b1;
  end
  // pending request consumed by IDLE; only taken when no check is running
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pend <= AUTO_START;
    else pend <= (state == S_IDLE && pend) ? 1'b0 : (start_ok && (state == S_IDLE || done)) ? 1'b1 : pend;
  end
  // capture words and comparisons; match flags publish together when the timestamp lands
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_value    <= '0;
      ts_value    <= '0;
      id_eq       <= 1'b0;
      id_match    <= 1'b0;
      ts_match    <= 1'b0;
      timeout_err <= 1'b0;
    end else if (done && start_ok) begin
      id_value    <= '0;
      ts_value    <= '0;
      id_eq       <= 1'b0;
      id_match    <= 1'b0;
      ts_match    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (capture && !is_ts) begin
        id_value <= sysid.readdata;
        id_eq    <= sysid.readdata == EXPECTED_ID;
      end
      if (capture && is_ts) begin
        ts_value <= sysid.readdata;
        ts_match <= sysid.readdata == EXPECTED_TS;
        id_match <= id_eq;
      end
      if (timeout) begin
        timeout_err <= 1'b1;
        id_match    <= 1'b0;
        ts_match    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: directed and randomized checks of sysid_checker against a timing/result model
module tb_sysid_checker;
  localparam logic [31:0] E_ID = 32'h0000_0000;
  localparam logic [31:0] E_TS = 32'd1392150940;
  localparam int TMO_A = 8;
  localparam int LAT_B = 2;
  localparam int TMO_B = 255;

  typedef struct {
    int st0, st1;
    logic [31:0] m0, m1;
    int left;
    bit fresh;
    bit pv;
    int pc;
    logic [31:0] pd;
  } slave_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, start_a, start_b;
  logic busy_a, done_a, idm_a, tsm_a, to_a;
  logic busy_b, done_b, idm_b, tsm_b, to_b;
  logic [31:0] idv_a, tsv_a, idv_b, tsv_b;
  logic wa, wb;
  logic [31:0] da, db;
  slave_t sa, sb;
  int n_chk = 0;
  int n_fail = 0;

  sysid_if bus_a();
  sysid_if bus_b();

  sysid_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(TMO_A), .AUTO_START(1'b1)) dut_a (
    .clock(clk), .reset_n(rst_a), .start(start_a), .sysid(bus_a),
    .busy(busy_a), .done(done_a), .id_match(idm_a), .ts_match(tsm_a),
    .id_value(idv_a), .ts_value(tsv_a), .timeout_err(to_a)
  );

  sysid_checker #(.READ_LATENCY(LAT_B), .TIMEOUT_CYCLES(TMO_B), .AUTO_START(1'b0)) dut_b (
    .clock(clk), .reset_n(rst_b), .start(start_b), .sysid(bus_b),
    .busy(busy_b), .done(done_b), .id_match(idm_b), .ts_match(tsm_b),
    .id_value(idv_b), .ts_value(tsv_b), .timeout_err(to_b)
  );

  // behavioural slave: stalls a configured number of cycles per read, returns data after lat cycles
  task automatic slave_step(inout slave_t s, input logic rd, input logic ad, input int lat,
                            output logic w, output logic [31:0] d);
    if (rd !== 1'b1) s.fresh = 1;
    else if (s.fresh) begin
      s.left = ad ? s.st1 : s.st0;
      s.fresh = 0;
    end
    w = (rd === 1'b1) && s.left > 0;
    if (w) s.left--;
    if (s.pv) s.pc--;
    d = (lat == 0) ? (ad ? s.m1 : s.m0) : (s.pv && s.pc == 0) ? s.pd : 32'hBAD0_BAD0;
    if (s.pv && s.pc == 0) s.pv = 0;
    if (rd === 1'b1 && !w) begin
      s.fresh = 1;
      if (lat > 0) begin
        s.pv = 1;
        s.pc = lat;
        s.pd = ad ? s.m1 : s.m0;
      end
    end
  endtask

  always @(negedge clk) begin
    slave_step(sa, bus_a.read, bus_a.address, 0, wa, da);
    bus_a.waitrequest = wa;
    bus_a.readdata = da;
    slave_step(sb, bus_b.read, bus_b.address, LAT_B, wb, db);
    bus_b.waitrequest = wb;
    bus_b.readdata = db;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // edges from the sampled start until done, derived from per-read cost (stalls + accept + latency)
  function automatic int exp_cyc(input int s0, input int s1, input int lat, input int tmo);
    if (s0 >= tmo) return 1 + tmo;
    if (s1 >= tmo) return 1 + (s0 + 1 + lat) + tmo;
    return 1 + (s0 + 1 + lat) + (s1 + 1 + lat);
  endfunction

  function automatic int exp_rdc(input int s0, input int s1, input int tmo);
    if (s0 >= tmo) return tmo;
    if (s1 >= tmo) return s0 + 1 + tmo;
    return s0 + s1 + 2;
  endfunction

  task automatic wait_done(input int u, output int n, output int rdc);
    n = 0;
    rdc = 0;
    while (n < 300 && !(u != 0 ? done_b : done_a)) begin
      @(posedge clk);
      #1;
      n++;
      if ((u != 0 ? bus_b.read : bus_a.read) === 1'b1) rdc++;
    end
  endtask

  task automatic run(input int u, input int s0, input int s1, input logic [31:0] m0, input logic [31:0] m1);
    int n, rdc, lat, tmo;
    bit to;
    lat = (u != 0) ? LAT_B : 0;
    tmo = (u != 0) ? TMO_B : TMO_A;
    @(posedge clk);
    #1;
    if (u != 0) begin
      sb.st0 = s0; sb.st1 = s1; sb.m0 = m0; sb.m1 = m1; start_b = 1;
    end else begin
      sa.st0 = s0; sa.st1 = s1; sa.m0 = m0; sa.m1 = m1; start_a = 1;
    end
    @(posedge clk);
    #1;
    start_a = 0;
    start_b = 0;
    chk("start_clears_done", u != 0 ? done_b : done_a, 0);
    chk("start_clears_ts", u != 0 ? tsv_b : tsv_a, 0);
    chk("start_clears_to", u != 0 ? to_b : to_a, 0);
    wait_done(u, n, rdc);
    to = s0 >= tmo || s1 >= tmo;
    chk("done_cycles", n, exp_cyc(s0, s1, lat, tmo));
    chk("read_cycles", rdc, exp_rdc(s0, s1, tmo));
    chk("busy_in_done", u != 0 ? busy_b : busy_a, 0);
    chk("id_value", u != 0 ? idv_b : idv_a, s0 >= tmo ? 32'h0 : m0);
    chk("ts_value", u != 0 ? tsv_b : tsv_a, to ? 32'h0 : m1);
    chk("id_match", u != 0 ? idm_b : idm_a, !to && m0 == E_ID);
    chk("ts_match", u != 0 ? tsm_b : tsm_a, !to && m1 == E_TS);
    chk("timeout_err", u != 0 ? to_b : to_a, to);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rdc;
    sa = '{st0: 0, st1: 0, m0: E_ID, m1: E_TS, left: 0, fresh: 1, pv: 0, pc: 0, pd: 0};
    sb = sa;
    rst_a = 0;
    rst_b = 0;
    start_a = 0;
    start_b = 0;
    #1;
    chk("rst_read", bus_a.read, 0);
    chk("rst_addr", bus_a.address, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_idv", idv_a, 0);
    chk("rst_tsv", tsv_a, 0);
    chk("rst_flags", {idm_a, tsm_a, to_a}, 0);
    #21;
    rst_a = 1;
    rst_b = 1;
    start_b = 1;
    @(posedge clk);
    #1;
    start_b = 0;
    chk("auto_id_read", {bus_a.read, bus_a.address}, 2'b10);
    @(posedge clk);
    #1;
    chk("auto_ts_read", {bus_a.read, bus_a.address}, 2'b11);
    @(posedge clk);
    #1;
    chk("auto_done", done_a, 1);
    chk("auto_busy", busy_a, 0);
    chk("auto_read_off", bus_a.read, 0);
    chk("auto_idm", idm_a, 1);
    chk("auto_tsm", tsm_a, 1);
    chk("auto_tsv", tsv_a, 32'h52FA899C);
    chk("auto_to", to_a, 0);
    chk("start_at_release_busy", busy_b, 0);
    chk("start_at_release_done", done_b, 0);

    run(0, 0, 0, E_ID, 32'h52FA899D);
    run(0, 0, 8, E_ID, E_TS);
    run(0, 8, 0, 32'h1234_5678, E_TS);
    run(0, 7, 7, E_ID, E_TS);
    run(0, 0, 0, 32'h8000_0000, E_TS);
    run(1, 3, 3, E_ID, E_TS);
    run(1, 0, 0, E_ID, E_TS ^ 32'h8000_0000);

    @(posedge clk);
    #1;
    sa.st0 = 0; sa.st1 = 4; sa.m0 = E_ID; sa.m1 = E_TS; start_a = 1;
    @(posedge clk);
    #1;
    start_a = 0;
    @(posedge clk);
    #1;
    chk("busy_id_read", {bus_a.read, bus_a.address}, 2'b10);
    @(posedge clk);
    #1;
    chk("busy_ts_read", {bus_a.read, bus_a.address}, 2'b11);
    start_a = 1;
    @(posedge clk);
    #1;
    start_a = 0;
    wait_done(0, n, rdc);
    chk("busy_start_cycles", n, exp_cyc(0, 4, 0, TMO_A) - 3);
    repeat (4) @(posedge clk);
    #1;
    chk("no_queued_rerun_done", done_a, 1);
    chk("no_queued_rerun_busy", busy_a, 0);
    chk("no_queued_rerun_tsm", tsm_a, 1);
    run(0, 0, 2, E_ID, E_TS);

    @(posedge clk);
    #1;
    sa.st0 = 20; sa.st1 = 0; start_a = 1;
    @(posedge clk);
    #1;
    start_a = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("midwait_read", bus_a.read, 1);
    #2;
    rst_a = 0;
    #1;
    chk("async_rst_read", bus_a.read, 0);
    chk("async_rst_busy", busy_a, 0);
    chk("async_rst_done", done_a, 0);
    chk("async_rst_vals", {idv_a, tsv_a}, 64'h0);
    sa.st0 = 0;
    @(negedge clk);
    rst_a = 1;
    wait_done(0, n, rdc);
    chk("restart_cycles", n, 3);
    chk("restart_flags", {idm_a, tsm_a, to_a}, 3'b110);

    for (int i = 0; i < 8; i++) begin
      run(0, $urandom_range(0, 9), $urandom_range(0, 9),
          $urandom_range(0, 1) != 0 ? E_ID : 32'($urandom),
          $urandom_range(0, 1) != 0 ? E_TS : 32'($urandom));
      run(1, $urandom_range(0, 4), $urandom_range(0, 4),
          $urandom_range(0, 1) != 0 ? E_ID : 32'($urandom),
          $urandom_range(0, 1) != 0 ? E_TS : 32'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
